horner_eval_seq: RTL and testbench

- Parametrised, fixed-point successor to the single-loop Horner block. Evaluates y = c_N*x^N + ... + c_1*x + c_0 for a run-time order N ≤ MAX_ORDER.
- Uses one multiply-accumulate step per clock and an internal, writable coefficient register file.
- Sits between the ADC sample path and the linearised-output consumer, using the srdyi_i/srdyo_o handshake.
- Adds round-half-up rounding, per-step saturation and an overflow flag.

---
 rtl/horner_eval_seq.sv | 172 +++++++++++++++++
 tb/tb_horner_eval_seq.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/horner_eval_seq.sv
// horner_eval_seq
// Fixed-point polynomial evaluator using Horner's rule:
//   y = c_N*x^N + ... + c_1*x + c_0, with the order N <= MAX_ORDER chosen per sample.
// One multiply-accumulate step runs per clock. Coefficients live in an internal
// register file that can be written while the block is idle.
//
// Ports
//   Clock         rising-edge clock
//   GlobalReset   synchronous, active-low reset
//   x_i           signed sample (FRAC fractional bits), latched on accept
//   srdyi_i       sample valid
//   order_i       polynomial order N, clamped to MAX_ORDER, latched on accept
//   coeff_we_i    coefficient write strobe (honoured only while idle)
//   coeff_addr_i  coefficient index k
//   coeff_data_i  coefficient value c_k (FRAC fractional bits)
//   busy_o        high while the MAC state is active
//   y_o           registered result, held until the next result
//   srdyo_o       one-cycle result-valid pulse
//   ovf_o         saturation occurred while producing the current y_o
//
// Handshake: there is no back-pressure. A sample is accepted on any clock edge
// where srdyi_i=1 while the block is idle (busy_o=0); srdyi_i during MAC is
// dropped. Each accepted sample yields exactly one srdyo_o pulse, N+1 edges after
// the accept edge. The block is idle during the srdyo_o cycle, so a new sample
// may be accepted in that same cycle.
module horner_eval_seq #(
  parameter int X_W       = 21,
  parameter int C_W       = 24,
  parameter int FRAC      = 16,
  parameter int ACC_W     = 40,
  parameter int OUT_W     = 21,
  parameter int MAX_ORDER = 7,
  parameter int ORDER_W   = 3
) (
  input  logic               Clock,
  input  logic               GlobalReset,
  input  logic [X_W-1:0]     x_i,
  input  logic               srdyi_i,
  input  logic [ORDER_W-1:0] order_i,
  input  logic               coeff_we_i,
  input  logic [ORDER_W-1:0] coeff_addr_i,
  input  logic [C_W-1:0]     coeff_data_i,
  output logic               busy_o,
  output logic [OUT_W-1:0]   y_o,
  output logic               srdyo_o,
  output logic               ovf_o
);

  // Full-precision product width.
  localparam int PW = ACC_W + X_W;

  // 2^(FRAC-1), the round-half-up offset.
  localparam logic signed [PW-1:0] HALF = {{(PW-FRAC){1'b0}}, 1'b1, {(FRAC-1){1'b0}}};

  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
  localparam logic signed [OUT_W-1:0] OUT_MAX = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic signed [OUT_W-1:0] OUT_MIN = {1'b1, {(OUT_W-1){1'b0}}};

  typedef enum logic {
    IDLE = 1'b0,
    MAC  = 1'b1
  } state_t;

  state_t                    state;
  logic signed [X_W-1:0]     x_r;
  logic [ORDER_W-1:0]        k;
  logic signed [ACC_W-1:0]   acc;
  logic                      sticky;
  logic signed [C_W-1:0]     coef [MAX_ORDER+1];

  // Accept-side decode
  logic [ORDER_W-1:0]        order_sel;
  logic                      addr_ok;

  // One Horner step
  logic signed [PW-1:0]      prod;
  logic signed [PW-1:0]      rsum;
  logic signed [PW-1:0]      t;
  logic                      t_fits;
  logic signed [ACC_W-1:0]   t_sat;
  logic signed [C_W-1:0]     c_next;
  logic signed [ACC_W:0]     s2;
  logic                      s2_fits;
  logic signed [ACC_W-1:0]   acc_step;
  logic                      step_sat;

  // Output conversion
  logic                      out_fits;
  logic signed [OUT_W-1:0]   y_sat;

  assign busy_o = (state == MAC);

  always_comb begin
    order_sel = order_i;
    if (int'(order_i) > MAX_ORDER) begin
      order_sel = ORDER_W'(MAX_ORDER);
    end
    addr_ok = (int'(coeff_addr_i) <= MAX_ORDER);
  end

  always_comb begin
    prod   = PW'(acc) * PW'(x_r);
    rsum   = prod + HALF;
    t      = rsum >>> FRAC;
    // t fits in ACC_W bits when every bit above the accumulator sign bit
    // matches the sign.
    t_fits = (t[PW-1:ACC_W-1] == {(PW-ACC_W+1){t[PW-1]}});
    t_sat  = t_fits ? t[ACC_W-1:0] : (t[PW-1] ? ACC_MIN : ACC_MAX);

    c_next = coef[k - 1'b1];
    // One guard bit is enough for the sum of two in-range values.
    s2       = {t_sat[ACC_W-1], t_sat} + {{(ACC_W+1-C_W){c_next[C_W-1]}}, c_next};
    s2_fits  = (s2[ACC_W] == s2[ACC_W-1]);
    acc_step = s2_fits ? s2[ACC_W-1:0] : (s2[ACC_W] ? ACC_MIN : ACC_MAX);
    step_sat = !t_fits || !s2_fits;

    out_fits = (acc[ACC_W-1:OUT_W-1] == {(ACC_W-OUT_W+1){acc[ACC_W-1]}});
    y_sat    = out_fits ? acc[OUT_W-1:0] : (acc[ACC_W-1] ? OUT_MIN : OUT_MAX);
  end

  always_ff @(posedge Clock) begin
    if (!GlobalReset) begin
      state   <= IDLE;
      x_r     <= '0;
      k       <= '0;
      acc     <= '0;
      sticky  <= 1'b0;
      y_o     <= '0;
      srdyo_o <= 1'b0;
      ovf_o   <= 1'b0;
      for (int i = 0; i <= MAX_ORDER; i++) begin
        coef[i] <= '0;
      end
    end else begin
      srdyo_o <= 1'b0;
      case (state)
        IDLE: begin
          if (srdyi_i) begin
            x_r    <= x_i;
            k      <= order_sel;
            acc    <= {{(ACC_W-C_W){coef[order_sel][C_W-1]}}, coef[order_sel]};
            sticky <= 1'b0;
            state  <= MAC;
          end
          // Non-blocking write: an accept on this same edge still reads the
          // old coefficient.
          if (coeff_we_i && addr_ok) begin
            coef[coeff_addr_i] <= coeff_data_i;
          end
        end
        MAC: begin
          if (k == '0) begin
            y_o     <= y_sat;
            ovf_o   <= sticky || !out_fits;
            srdyo_o <= 1'b1;
            sticky  <= 1'b0;
            state   <= IDLE;
          end else begin
            acc <= acc_step;
            k   <= k - 1'b1;
            if (step_sat) begin
              sticky <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_horner_eval_seq.sv
// Testbench for horner_eval_seq: directed scenarios followed by randomized
// evaluations, all checked against a plain-arithmetic polynomial model.
module tb_horner_eval_seq;

  localparam int X_W       = 21;
  localparam int C_W       = 24;
  localparam int FRAC      = 16;
  localparam int ACC_W     = 40;
  localparam int OUT_W     = 21;
  localparam int MAX_ORDER = 7;
  localparam int ORDER_W   = 3;

  localparam longint ACC_HI = (longint'(1) <<< (ACC_W-1)) - 1;
  localparam longint ACC_LO = -(longint'(1) <<< (ACC_W-1));
  localparam longint OUT_HI = (longint'(1) <<< (OUT_W-1)) - 1;
  localparam longint OUT_LO = -(longint'(1) <<< (OUT_W-1));

  // ---------------- clock / reset / DUT ----------------
  logic               Clock = 1'b0;
  logic               GlobalReset;
  logic [X_W-1:0]     x_i;
  logic               srdyi_i;
  logic [ORDER_W-1:0] order_i;
  logic               coeff_we_i;
  logic [ORDER_W-1:0] coeff_addr_i;
  logic [C_W-1:0]     coeff_data_i;
  logic               busy_o;
  logic [OUT_W-1:0]   y_o;
  logic               srdyo_o;
  logic               ovf_o;

  always #5 Clock = ~Clock;

  horner_eval_seq #(
    .X_W(X_W), .C_W(C_W), .FRAC(FRAC), .ACC_W(ACC_W), .OUT_W(OUT_W),
    .MAX_ORDER(MAX_ORDER), .ORDER_W(ORDER_W)
  ) dut (
    .Clock(Clock),
    .GlobalReset(GlobalReset),
    .x_i(x_i),
    .srdyi_i(srdyi_i),
    .order_i(order_i),
    .coeff_we_i(coeff_we_i),
    .coeff_addr_i(coeff_addr_i),
    .coeff_data_i(coeff_data_i),
    .busy_o(busy_o),
    .y_o(y_o),
    .srdyo_o(srdyo_o),
    .ovf_o(ovf_o)
  );

  // ---------------- scoreboard state ----------------
  int               errors = 0;
  int               checks = 0;
  longint           mc [MAX_ORDER+1];
  logic [OUT_W-1:0] exp_q[$];
  logic             exp_ovf_q[$];

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  // Polynomial model: Horner's rule on plain integers with rounding and clamping.
  function automatic longint clamp(input longint v, input longint lo, input longint hi, inout bit ovf);
    if (v > hi) begin ovf = 1'b1; return hi; end
    if (v < lo) begin ovf = 1'b1; return lo; end
    return v;
  endfunction

  function automatic void model_eval(input longint x, input int n_in, output longint y, output bit ovf);
    longint a;
    longint t;
    int     n;
    ovf = 1'b0;
    n = (n_in > MAX_ORDER) ? MAX_ORDER : n_in;
    a = mc[n];
    for (int j = n; j > 0; j--) begin
      t = (a * x + (longint'(1) <<< (FRAC-1))) >>> FRAC;
      t = clamp(t, ACC_LO, ACC_HI, ovf);
      a = clamp(t + mc[j-1], ACC_LO, ACC_HI, ovf);
    end
    y = clamp(a, OUT_LO, OUT_HI, ovf);
  endfunction

  // ---------------- driver tasks ----------------
  task automatic step();
    @(negedge Clock);
  endtask

  task automatic do_reset();
    GlobalReset = 1'b0;
    step();
    step();
    GlobalReset = 1'b1;
    for (int j = 0; j <= MAX_ORDER; j++) mc[j] = 0;
  endtask

  task automatic write_coef(input int idx, input longint v);
    coeff_we_i   = 1'b1;
    coeff_addr_i = ORDER_W'(idx);
    coeff_data_i = C_W'(v);
    step();
    coeff_we_i   = 1'b0;
    mc[idx]      = v;
  endtask

  task automatic accept(input longint x, input int n);
    x_i     = X_W'(x);
    order_i = ORDER_W'(n);
    srdyi_i = 1'b1;
    step();
    srdyi_i = 1'b0;
  endtask

  // Waits for the result of the sample accepted `pre` edges ago (busy was
  // already confirmed for those cycles) and checks it against the queue head.
  task automatic wait_result(input string tag, input int n, input int pre);
    int edges;
    int busy_cnt;
    bit seen;
    logic [OUT_W-1:0] ey;
    logic eo;
    edges    = pre;
    busy_cnt = pre;
    seen     = 1'b0;
    while (edges < 40) begin
      busy_cnt += int'(busy_o);
      step();
      edges++;
      if (srdyo_o) begin
        seen = 1'b1;
        break;
      end
    end
    chk({tag, " result_seen"}, 64'(seen), 1);
    ey = exp_q.pop_front();
    eo = exp_ovf_q.pop_front();
    if (seen) begin
      chk({tag, " latency"}, edges, n + 1);
      chk({tag, " busy_cycles"}, busy_cnt, n + 1);
      chk({tag, " idle_at_result"}, 64'(busy_o), 0);
      chk({tag, " y"}, $signed(y_o), $signed(ey));
      chk({tag, " ovf"}, 64'(ovf_o), 64'(eo));
      step();
      chk({tag, " pulse_width"}, 64'(srdyo_o), 0);
    end
  endtask

  task automatic eval_const(input string tag, input longint x, input int n, input longint ey, input bit eo);
    exp_q.push_back(OUT_W'(ey));
    exp_ovf_q.push_back(eo);
    accept(x, n);
    wait_result(tag, n, 0);
  endtask

  task automatic eval_model(input string tag, input longint x, input int n);
    longint y;
    bit o;
    model_eval(x, n, y, o);
    exp_q.push_back(OUT_W'(y));
    exp_ovf_q.push_back(o);
    accept(x, n);
    wait_result(tag, n, 0);
  endtask

  task automatic load_scenario1();
    write_coef(0, 65536);
    write_coef(1, 32768);
    write_coef(2, 16384);
  endtask

  function automatic longint rand_coef();
    logic [C_W-1:0] r;
    if ($urandom_range(0, 3) == 0) begin
      r = C_W'($urandom);
      return longint'($signed(r));
    end
    return longint'($urandom_range(0, 262143)) - 131072;
  endfunction

  function automatic longint rand_x();
    logic [X_W-1:0] r;
    if ($urandom_range(0, 3) == 0) begin
      r = X_W'($urandom);
      return longint'($signed(r));
    end
    return longint'($urandom_range(0, 524287)) - 262144;
  endfunction

  // ---------------- directed + random sequence ----------------
  initial begin
    int pulses;
    int last;
    GlobalReset  = 1'b0;
    x_i          = '0;
    srdyi_i      = 1'b0;
    order_i      = '0;
    coeff_we_i   = 1'b0;
    coeff_addr_i = '0;
    coeff_data_i = '0;
    do_reset();

    chk("reset busy", 64'(busy_o), 0);
    chk("reset srdyo", 64'(srdyo_o), 0);
    chk("reset ovf", 64'(ovf_o), 0);
    chk("reset y", $signed(y_o), 0);

    // Basic Horner evaluation: 0.25*4 + 0.5*2 + 1 = 3.0
    load_scenario1();
    eval_const("horner", 131072, 2, 196608, 1'b0);

    // Order 0 returns c0; negative x: 0.25*4 - 1 + 1 = 1.0
    eval_const("order0", 131072, 0, 65536, 1'b0);
    eval_const("neg_x", -131072, 2, 65536, 1'b0);

    // Round half up: 0.5 LSB -> 1, -0.5 LSB -> 0
    write_coef(0, 0);
    write_coef(1, 32768);
    eval_const("round_up", 1, 1, 1, 1'b0);
    write_coef(1, -32768);
    eval_const("round_neg", 1, 1, 0, 1'b0);

    // Output saturation, then a clean run clears the flag
    write_coef(1, 8388607);
    write_coef(0, 0);
    eval_const("saturate", 1048575, 1, 1048575, 1'b1);
    load_scenario1();
    eval_const("ovf_clear", 131072, 2, 196608, 1'b0);

    // srdyi_i held high: each new accept lands in the srdyo_o cycle, so
    // results repeat every N+2 = 4 edges.
    x_i     = X_W'(131072);
    order_i = ORDER_W'(2);
    srdyi_i = 1'b1;
    pulses  = 0;
    last    = 0;
    for (int c = 1; c <= 16; c++) begin
      step();
      if (srdyo_o) begin
        pulses++;
        chk("b2b spacing", c - last, 4);
        chk("b2b y", $signed(y_o), 196608);
        last = c;
      end
    end
    srdyi_i = 1'b0;
    chk("b2b pulses", pulses, 4);
    step();
    chk("b2b idle_after", 64'(busy_o), 0);

    // srdyi_i during MAC is dropped
    exp_q.push_back(OUT_W'(196608));
    exp_ovf_q.push_back(1'b0);
    accept(131072, 2);
    chk("drop busy", 64'(busy_o), 1);
    x_i     = '0;
    order_i = '0;
    srdyi_i = 1'b1;
    step();
    srdyi_i = 1'b0;
    wait_result("drop", 2, 1);
    pulses = 0;
    for (int c = 0; c < 6; c++) begin
      step();
      pulses += int'(srdyo_o);
    end
    chk("drop extra_pulses", pulses, 0);

    // Coefficient write during MAC is ignored (c0 still 1.0)
    exp_q.push_back(OUT_W'(196608));
    exp_ovf_q.push_back(1'b0);
    accept(131072, 2);
    chk("wr_busy busy", 64'(busy_o), 1);
    coeff_we_i   = 1'b1;
    coeff_addr_i = '0;
    coeff_data_i = '0;
    step();
    coeff_we_i   = 1'b0;
    wait_result("wr_busy", 2, 1);
    eval_const("wr_busy c0", 0, 0, 65536, 1'b0);

    // Write to c[n] on the accept edge: evaluation uses the old value
    exp_q.push_back(OUT_W'(196608));
    exp_ovf_q.push_back(1'b0);
    x_i          = X_W'(131072);
    order_i      = ORDER_W'(2);
    srdyi_i      = 1'b1;
    coeff_we_i   = 1'b1;
    coeff_addr_i = ORDER_W'(2);
    coeff_data_i = '0;
    step();
    srdyi_i    = 1'b0;
    coeff_we_i = 1'b0;
    mc[2]      = 0;
    wait_result("wr_accept", 2, 0);
    eval_const("wr_after", 131072, 2, 131072, 1'b0);

    // Randomized evaluations against the model
    for (int it = 0; it < 25; it++) begin
      for (int j = 0; j <= MAX_ORDER; j++) write_coef(j, rand_coef());
      eval_model("random", rand_x(), int'($urandom_range(0, MAX_ORDER)));
    end

    // Reset during the second MAC cycle aborts the evaluation
    load_scenario1();
    eval_const("pre_reset", 131072, 2, 196608, 1'b0);
    accept(131072, 2);
    step();
    GlobalReset = 1'b0;
    step();
    GlobalReset = 1'b1;
    for (int j = 0; j <= MAX_ORDER; j++) mc[j] = 0;
    chk("midreset busy", 64'(busy_o), 0);
    chk("midreset y", $signed(y_o), 0);
    chk("midreset srdyo", 64'(srdyo_o), 0);
    pulses = 0;
    for (int c = 0; c < 6; c++) begin
      step();
      pulses += int'(srdyo_o);
    end
    chk("midreset no_result", pulses, 0);
    eval_const("post_reset", 131072, 2, 0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
